// File: rtl/piso_serial_tx_if.sv
// Load handshake and serial output bundle for piso_serial_tx.
// Parameterised on the parallel word width.
interface piso_serial_tx_if #(
   parameter int WIDTH = 8
);
   logic             LOAD;
   logic [WIDTH-1:0] DIN;
   logic             READY;
   logic             SOUT;
   logic             SVALID;
   logic             BUSY;
   logic             DONE;

   modport master (
      output LOAD, DIN,
      input  READY, SOUT, SVALID, BUSY, DONE
   );

   modport slave (
      input  LOAD, DIN,
      output READY, SOUT, SVALID, BUSY, DONE
   );
endinterface

// File: rtl/piso_serial_tx.sv
// Parallel-in/serial-out transmitter, MSB first, registered outputs.
// Define PISO_TX_PARITY_EN to append an even-parity bit to each frame.
module piso_serial_tx #(
   parameter int WIDTH = 8
) (
   input logic             CLK,
   input logic             RST,
   piso_serial_tx_if.slave bus
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sout_q, sout_d;
   logic             svalid_q, svalid_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;
   logic             done_q, done_d;
`ifdef PISO_TX_PARITY_EN
   logic             par_q, par_d;
`endif

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      cnt_d    = cnt_q;
      sout_d   = 1'b0;
      svalid_d = 1'b0;
      busy_d   = 1'b0;
      ready_d  = 1'b1;
      done_d   = 1'b0;
`ifdef PISO_TX_PARITY_EN
      par_d    = par_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.LOAD) begin
               state_d  = SHIFT;
               shift_d  = bus.DIN;
               cnt_d    = '0;
               sout_d   = bus.DIN[WIDTH-1];
               svalid_d = 1'b1;
               busy_d   = 1'b1;
               ready_d  = 1'b0;
`ifdef PISO_TX_PARITY_EN
               par_d    = ^bus.DIN;
`endif
            end
         end
         SHIFT: begin
            if (cnt_q == LAST) begin
`ifdef PISO_TX_PARITY_EN
               state_d  = PAR;
               sout_d   = par_q;
               svalid_d = 1'b1;
               busy_d   = 1'b1;
               ready_d  = 1'b0;
`else
               state_d  = IDLE;
               done_d   = 1'b1;
`endif
            end else begin
               // SOUT already shows shift_q MSB; move the next bit up
               shift_d  = {shift_q[WIDTH-2:0], 1'b0};
               cnt_d    = cnt_q + 1'b1;
               sout_d   = shift_q[WIDTH-2];
               svalid_d = 1'b1;
               busy_d   = 1'b1;
               ready_d  = 1'b0;
            end
         end
`ifdef PISO_TX_PARITY_EN
         PAR: begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
         sout_q   <= 1'b0;
         svalid_q <= 1'b0;
         busy_q   <= 1'b0;
         ready_q  <= 1'b1;
         done_q   <= 1'b0;
`ifdef PISO_TX_PARITY_EN
         par_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         cnt_q    <= cnt_d;
         sout_q   <= sout_d;
         svalid_q <= svalid_d;
         busy_q   <= busy_d;
         ready_q  <= ready_d;
         done_q   <= done_d;
`ifdef PISO_TX_PARITY_EN
         par_q    <= par_d;
`endif
      end
   end

   assign bus.SOUT   = sout_q;
   assign bus.SVALID = svalid_q;
   assign bus.BUSY   = busy_q;
   assign bus.READY  = ready_q;
   assign bus.DONE   = done_q;
endmodule
